fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch sequencer directly upstream of the fetch memory stage: owns the program counter, drives `pc` into the 512×16 instruction memory, and pairs each registered instruction coming back with its address. Presents a valid/stall stream to decode, yields the shared memory port to data loads, redirects on taken branches and stops on a HALT instruction.

## Interface
Parameters:
- `PC_W`, 9, program-counter width (512-word memory)
- `INST_W`, 16, instruction width
- `RESET_PC`, 0, first fetch address after reset

Ports (vectors use `[0:N-1]`, bit 0 = MSB):
- `ck`  in  1  clock, all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `mem_load`  in  1  memory port taken by a data load this edge; no instruction read occurs
- `inst`  in  INST_W  registered instruction from fetch memory, `mem[pc]` as sampled at the previous edge
- `stall`  in  1  decode not ready; current `inst_out` is not consumed
- `br_taken`  in  1  redirect request, single-cycle
- `br_target`  in  PC_W  redirect address
- `pc`  out  PC_W  fetch address to memory (registered)
- `inst_valid`  out  1  `inst_out`/`inst_pc` hold a valid instruction
- `inst_out`  out  INST_W  instruction to decode
- `inst_pc`  out  PC_W  address of `inst_out`
- `halted`  out  1  HALT accepted; fetch stopped

## Operation
- State: `RUN`, `HALT`. Internal registers: `f_valid`/`f_pc` (in-flight read), `hold_valid`/`hold_inst`/`hold_pc` (one-entry stall buffer).
- Output source: hold buffer if `hold_valid`, else `inst`/`f_pc` if `f_valid`. Otherwise `inst_valid`=0, with `inst_out`=0 and `inst_pc`=0.
- `accept` = `inst_valid & !stall`.
- Edge priority (RUN): `br_taken` > HALT accept > stall capture > normal.
- `br_taken`: `pc`<=`br_target`. Clear `f_valid` and `hold_valid`. An instruction accepted on the same edge counts as consumed; its HALT is ignored.
- HALT accept (accepted `inst_out[0:3]`==4'hF): state<=HALT, `f_valid`<=0, `pc` holds.
- Stall capture (`!hold_valid & f_valid & stall`): copy `inst`/`f_pc` into hold buffer, `hold_valid`<=1. Discard the read made this edge (`f_valid`<=0). `pc` holds.
- While `hold_valid & stall`: `f_valid`<=0, `pc` holds.
- When `hold_valid & !stall`: `hold_valid`<=0, then normal fetch rule applies on the same edge.
- Normal fetch: if `mem_load`=0, then `f_valid`<=1, `f_pc`<=`pc`, `pc`<=`pc`+1 (mod 2^PC_W, 511→0). If `mem_load`=1, then `f_valid`<=0 and `pc` holds.
- HALT: `inst_valid`=0, `halted`=1, `pc` frozen. `br_taken` and `mem_load` are ignored. Exit only by `rst`.

## Timing
- Reset values: `pc`=RESET_PC, `inst_valid`=0, `inst_out`=0, `inst_pc`=0, `halted`=0. Internally, `f_valid`=0, `hold_valid`=0, state RUN.
- Reset may assert mid-stream. Any in-flight or held instruction is dropped, with no output glitch beyond the async clear.
- Fetch latency: `pc` at edge N → `inst_valid`=1 with `inst_out`=`mem[pc]` after edge N.
- Sustained throughput is 1 instruction/cycle with `stall`=0 and `mem_load`=0.
- Stall costs no refetch: the held instruction is presented the cycle after capture.
- Each `mem_load` edge inserts exactly one bubble.
- Branch: `br_target` instruction is valid 2 edges after the `br_taken` edge (one redirect edge, one read).

## Configuration
- `FETCH_CTRL_PERF_EN` defined adds outputs `fetch_cnt` (16-bit, increments per `accept`) and `bubble_cnt` (16-bit, increments per RUN cycle with `inst_valid`=0).
- Both counters saturate at 16'hFFFF and reset to 0.
- `FETCH_CTRL_PERF_EN` undefined: ports and counters are absent, and behaviour is otherwise identical.

## Structure
- Shared package `cpu_pkg`: `PC_W`, `INST_W`, `OP_HALT`=4'hF, opcode field slice constants, state enum `fetch_state_t`.
- Sub-module `inst_hold_buf`: one-entry instruction+pc register with capture/release, and the output mux.

## Test plan
- Reset release, mem `[0]=16'h9103,[1]=16'h9201,[2]=16'h0120`, `stall`=0.
  - Required: `inst_pc` 0,1,2 on consecutive cycles with matching `inst_out`, and `pc`=3 after the third edge.
- `stall` high 3 cycles while `inst_pc`=1.
  - Required: `inst_out`=16'h9201 held all 3 cycles and `pc` frozen at 2.
  - On release, `inst_pc`=2 follows with no duplicate and no skipped address.
- `mem_load`=1 for 2 edges mid-stream.
  - Required: exactly 2 cycles of `inst_valid`=0, then the sequence resumes at the next address.
- `br_taken`=1, `br_target`=9'h0A0 while `inst_pc`=4.
  - Required: instruction 5 never valid, and `inst_pc`=0x0A0 valid 2 edges later.
- Accept 16'hF000 at `inst_pc`=5.
  - Required: `halted`=1 the next cycle, `inst_valid` stays 0, and `pc` is unchanged for 10 cycles despite `br_taken` pulses.
- Start at `RESET_PC`=511.
  - Required: `inst_pc` 511 then 0.
- `rst` asserted while `hold_valid`=1.
  - Required: outputs clear immediately, and `inst_pc`=RESET_PC is valid one edge after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch front end.
// Provides default memory geometry, the HALT opcode, the opcode field slice
// and the fetch sequencer state type. Vectors use [0:N-1], bit 0 = MSB.
package cpu_pkg;

  localparam int unsigned PC_W   = 9;   // 512-word instruction memory
  localparam int unsigned INST_W = 16;
  localparam int unsigned PERF_W = 16;

  // Opcode occupies the top nibble: inst[OPC_HI:OPC_LO] with bit 0 = MSB.
  localparam int unsigned OPC_HI = 0;
  localparam int unsigned OPC_LO = 3;

  localparam logic [0:3] OP_HALT = 4'hF;

  typedef enum logic {
    StRun,
    StHalt
  } fetch_state_t;

endpackage

// File: rtl/inst_hold_buf.sv
// One-entry instruction/pc stall buffer plus the decode-side output mux.
// Ports:
//   i_ck, i_rst      clock, asynchronous active-high reset
//   i_run            sequencer is in RUN; outputs forced idle otherwise
//   i_capture        load i_f_inst/i_f_pc into the buffer
//   i_clear          drop the buffered entry (release or redirect)
//   i_f_valid        in-flight read is valid
//   i_f_inst/i_f_pc  in-flight instruction and its address
//   o_hold_valid     buffer holds an entry
//   o_valid/o_inst/o_pc  instruction presented to decode
module inst_hold_buf #(
  parameter int unsigned PC_W   = cpu_pkg::PC_W,
  parameter int unsigned INST_W = cpu_pkg::INST_W
) (
  input  logic              i_ck,
  input  logic              i_rst,
  input  logic              i_run,
  input  logic              i_capture,
  input  logic              i_clear,
  input  logic              i_f_valid,
  input  logic [0:INST_W-1] i_f_inst,
  input  logic [0:PC_W-1]   i_f_pc,
  output logic              o_hold_valid,
  output logic              o_valid,
  output logic [0:INST_W-1] o_inst,
  output logic [0:PC_W-1]   o_pc
);

  logic              r_valid;
  logic [0:INST_W-1] r_inst;
  logic [0:PC_W-1]   r_pc;

  always_ff @(posedge i_ck or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_inst  <= '0;
      r_pc    <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_capture) begin
      r_valid <= 1'b1;
      r_inst  <= i_f_inst;
      r_pc    <= i_f_pc;
    end
  end

  // Held entry takes precedence over the live memory read.
  always_comb begin
    o_valid = 1'b0;
    o_inst  = '0;
    o_pc    = '0;
    if (i_run) begin
      if (r_valid) begin
        o_valid = 1'b1;
        o_inst  = r_inst;
        o_pc    = r_pc;
      end else if (i_f_valid) begin
        o_valid = 1'b1;
        o_inst  = i_f_inst;
        o_pc    = i_f_pc;
      end
    end
  end

  assign o_hold_valid = r_valid;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, pairs registered memory data with
// its address, presents a valid/stall stream to decode, yields to data loads,
// redirects on taken branches and stops on HALT.
// Ports:
//   ck, rst            clock, asynchronous active-high reset
//   mem_load           memory port used by a data load this edge
//   inst               registered instruction, mem[pc] from the previous edge
//   stall              decode not ready
//   br_taken/br_target single-cycle redirect
//   pc                 fetch address (registered)
//   inst_valid/inst_out/inst_pc  instruction to decode
//   halted             HALT accepted
//   fetch_cnt/bubble_cnt  saturating counters, only with FETCH_CTRL_PERF_EN
module fetch_ctrl #(
  parameter int unsigned PC_W     = cpu_pkg::PC_W,
  parameter int unsigned INST_W   = cpu_pkg::INST_W,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              ck,
  input  logic              rst,
  input  logic              mem_load,
  input  logic [0:INST_W-1] inst,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [0:PC_W-1]   br_target,
  output logic [0:PC_W-1]   pc,
  output logic              inst_valid,
  output logic [0:INST_W-1] inst_out,
  output logic [0:PC_W-1]   inst_pc,
  output logic              halted
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [15:0]       fetch_cnt,
  output logic [15:0]       bubble_cnt
`endif
);

  import cpu_pkg::*;

  fetch_state_t    r_state;
  logic [0:PC_W-1] r_pc;
  logic [0:PC_W-1] r_f_pc;
  logic            r_f_valid;

  logic w_run;
  logic w_hold_valid;
  logic w_accept;
  logic w_halt_acc;
  logic w_capture;
  logic w_hold_clr;

  assign w_run = (r_state == StRun);

  inst_hold_buf #(
    .PC_W   (PC_W),
    .INST_W (INST_W)
  ) u_hold (
    .i_ck         (ck),
    .i_rst        (rst),
    .i_run        (w_run),
    .i_capture    (w_capture),
    .i_clear      (w_hold_clr),
    .i_f_valid    (r_f_valid),
    .i_f_inst     (inst),
    .i_f_pc       (r_f_pc),
    .o_hold_valid (w_hold_valid),
    .o_valid      (inst_valid),
    .o_inst       (inst_out),
    .o_pc         (inst_pc)
  );

  assign w_accept   = inst_valid & ~stall;
  assign w_halt_acc = w_accept & (inst_out[OPC_HI:OPC_LO] == OP_HALT);
  // A redirect on the same edge wins over capture; the live read is stale then.
  assign w_capture  = w_run & ~br_taken & ~w_hold_valid & r_f_valid & stall;
  assign w_hold_clr = w_run & w_hold_valid & (br_taken | ~stall);

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_state   <= StRun;
      r_pc      <= PC_W'(RESET_PC);
      r_f_pc    <= '0;
      r_f_valid <= 1'b0;
    end else if (r_state == StRun) begin
      if (br_taken) begin
        r_pc      <= br_target;
        r_f_valid <= 1'b0;
      end else if (w_halt_acc) begin
        r_state   <= StHalt;
        r_f_valid <= 1'b0;
      end else if (inst_valid & stall) begin
        // Covers both capture and holding: the read made this edge is dropped.
        r_f_valid <= 1'b0;
      end else if (mem_load) begin
        r_f_valid <= 1'b0;
      end else begin
        r_f_valid <= 1'b1;
        r_f_pc    <= r_pc;
        r_pc      <= r_pc + 1'b1;
      end
    end
  end

  assign pc     = r_pc;
  assign halted = ~w_run;

`ifdef FETCH_CTRL_PERF_EN
  logic [15:0] r_fetch_cnt;
  logic [15:0] r_bubble_cnt;

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_fetch_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_accept && (r_fetch_cnt != 16'hFFFF)) begin
        r_fetch_cnt <= r_fetch_cnt + 16'd1;
      end
      if (w_run && !inst_valid && (r_bubble_cnt != 16'hFFFF)) begin
        r_bubble_cnt <= r_bubble_cnt + 16'd1;
      end
    end
  end

  assign fetch_cnt  = r_fetch_cnt;
  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  logic        ck;
  logic        rst;
  logic        mem_load;
  logic        stall;
  logic        br_taken;
  logic [0:8]  br_target;
  logic [0:15] inst;
  logic [0:8]  pc;
  logic        inst_valid;
  logic [0:15] inst_out;
  logic [0:8]  inst_pc;
  logic        halted;

  logic [0:15] inst2;
  logic [0:8]  pc2;
  logic        inst_valid2;
  logic [0:15] inst_out2;
  logic [0:8]  inst_pc2;
  logic        halted2;

`ifdef FETCH_CTRL_PERF_EN
  logic [15:0] fetch_cnt, bubble_cnt, fetch_cnt2, bubble_cnt2;
`endif

  logic [0:15] mem [0:511];

  typedef struct {
    logic [0:8]  pc;
    logic [0:15] ins;
  } exp_t;
  exp_t q[$];

  int nchk = 0;
  int nerr = 0;

  fetch_ctrl #(.PC_W(9), .INST_W(16), .RESET_PC(0)) dut (
    .ck         (ck),
    .rst        (rst),
    .mem_load   (mem_load),
    .inst       (inst),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .pc         (pc),
    .inst_valid (inst_valid),
    .inst_out   (inst_out),
    .inst_pc    (inst_pc),
    .halted     (halted)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .fetch_cnt  (fetch_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  fetch_ctrl #(.PC_W(9), .INST_W(16), .RESET_PC(511)) dut2 (
    .ck         (ck),
    .rst        (rst),
    .mem_load   (1'b0),
    .inst       (inst2),
    .stall      (1'b0),
    .br_taken   (1'b0),
    .br_target  (9'h000),
    .pc         (pc2),
    .inst_valid (inst_valid2),
    .inst_out   (inst_out2),
    .inst_pc    (inst_pc2),
    .halted     (halted2)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .fetch_cnt  (fetch_cnt2),
    .bubble_cnt (bubble_cnt2)
`endif
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  // Registered instruction memory shared by both instances.
  always @(posedge ck) begin
    inst  <= mem[pc];
    inst2 <= mem[pc2];
  end

  // Monitor: every valid presentation must match the head of the queue;
  // it is popped only when decode accepts it.
  always @(negedge ck) begin
    if (inst_valid === 1'b1) begin
      nchk++;
      if (q.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_valid: inst_pc=%h inst_out=%h, required no valid output",
                 inst_pc, inst_out);
      end else begin
        if (inst_pc !== q[0].pc || inst_out !== q[0].ins) begin
          nerr++;
          $display("FAIL stream: inst_pc=%h inst_out=%h, required inst_pc=%h inst_out=%h",
                   inst_pc, inst_out, q[0].pc, q[0].ins);
        end
        if (stall == 1'b0) void'(q.pop_front());
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp_v);
    nchk++;
    if (act != exp_v) begin
      nerr++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp_v);
    end
  endtask

  task automatic push(input int a, input int d);
    exp_t e;
    e.pc  = 9'(a);
    e.ins = 16'(d);
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 16'h1000 | 16'(i);
    mem[0] = 16'h9103;
    mem[1] = 16'h9201;
    mem[2] = 16'h0120;
    mem[5] = 16'hF000;

    rst = 1'b1; stall = 1'b0; mem_load = 1'b0; br_taken = 1'b0; br_target = '0;
    repeat (2) @(posedge ck);
    #1;
    chk("reset_pc", pc, 0);
    chk("reset_valid", inst_valid, 0);
    chk("reset_inst_out", inst_out, 0);
    chk("reset_inst_pc", inst_pc, 0);
    chk("reset_halted", halted, 0);
    chk("reset_pc2", pc2, 511);

    // Straight-line fetch from reset; second instance starts at 511.
    push(0, 16'h9103); push(1, 16'h9201); push(2, 16'h0120);
    rst = 1'b0;
    step();
    chk("a_pc1", pc, 1);
    chk("wrap_valid0", inst_valid2, 1);
    chk("wrap_pc0", inst_pc2, 511);
    chk("wrap_inst0", inst_out2, 16'h11FF);
    step();
    chk("a_pc2", pc, 2);
    chk("wrap_pc1", inst_pc2, 0);
    chk("wrap_inst1", inst_out2, 16'h9103);
    step();
    chk("a_pc3", pc, 3);
    @(negedge ck);
    #1;
    chk("a_drain", q.size(), 0);
    rst = 1'b1;
    #1;
    chk("a_rst_valid", inst_valid, 0);

    // Stall, data-load bubbles, branch and HALT.
    step();
    push(0, 16'h9103); push(1, 16'h9201); push(2, 16'h0120);
    push(3, 16'h1003); push(4, 16'h1004);
    rst = 1'b0;
    step();
    step();
    chk("b_pc_pre_stall", pc, 2);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("b_stall_pc", pc, 2);
      chk("b_stall_valid", inst_valid, 1);
      chk("b_stall_inst", inst_out, 16'h9201);
    end
    stall = 1'b0;
    step();
    chk("b_release_pc", pc, 3);
    step();
    chk("b_pc4", pc, 4);
    mem_load = 1'b1;
    step();
    chk("b_load_bubble0", inst_valid, 0);
    step();
    chk("b_load_bubble1", inst_valid, 0);
    chk("b_load_pc", pc, 4);
    mem_load = 1'b0;
    step();
    chk("b_resume_valid", inst_valid, 1);
    chk("b_resume_inst_pc", inst_pc, 4);
    chk("b_resume_pc", pc, 5);

    push(9'h0A0, 16'h10A0);
    br_taken = 1'b1; br_target = 9'h0A0;
    step();
    br_taken = 1'b0;
    chk("br_redirect_valid", inst_valid, 0);
    chk("br_redirect_pc", pc, 9'h0A0);
    step();
    chk("br_target_valid", inst_valid, 1);
    chk("br_target_inst_pc", inst_pc, 9'h0A0);
    chk("br_target_pc", pc, 9'h0A1);

    push(5, 16'hF000);
    br_taken = 1'b1; br_target = 9'h005;
    step();
    br_taken = 1'b0;
    chk("br2_pc", pc, 5);
    step();
    chk("halt_inst_pc", inst_pc, 5);
    chk("halt_pre_pc", pc, 6);
    step();
    chk("halt_halted", halted, 1);
    chk("halt_valid", inst_valid, 0);
    for (int i = 0; i < 10; i++) begin
      br_taken  = (i % 2 == 0);
      mem_load  = (i % 2 != 0);
      br_target = 9'h033;
      step();
      chk("halt_pc_frozen", pc, 6);
      chk("halt_stays", halted, 1);
      chk("halt_no_valid", inst_valid, 0);
    end
    br_taken = 1'b0; mem_load = 1'b0;
    chk("b_drain", q.size(), 0);

    // Reset while an instruction sits in the stall buffer.
    rst = 1'b1;
    step();
    push(0, 16'h9103);
    rst = 1'b0;
    step();
    stall = 1'b1;
    step();
    chk("c_hold_inst_pc", inst_pc, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("c_rst_valid", inst_valid, 0);
    chk("c_rst_inst_out", inst_out, 0);
    chk("c_rst_inst_pc", inst_pc, 0);
    chk("c_rst_pc", pc, 0);
    chk("c_rst_halted", halted, 0);
    stall = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("c_post_valid", inst_valid, 1);
    chk("c_post_inst_pc", inst_pc, 0);
    @(negedge ck);
    #1;
    chk("c_drain", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
